// File: rtl/mul_sequencer.sv
// Iterative shift-and-add MUL/MLA unit that stalls the Execute stage.
// Each BUSY cycle retires one multiplier bit and stops early at the last set bit.
module mul_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        StartE,
    input  logic        AccE,
    input  logic        SetFlagsE,
    input  logic        FlushE,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    input  logic [31:0] SrcC,
    output logic        StallMul,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Result,
    output logic [1:0]  FlagsNZ,
    output logic [1:0]  FlagW
);

    localparam int unsigned DataW = 32;
    localparam int unsigned CntW  = 5;
    localparam logic [CntW-1:0] CntLast = CntW'(DataW - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [DataW-1:0]   mcand_q, mcand_d;
    logic [DataW-1:0]   mplier_q, mplier_d;
    logic [DataW-1:0]   acc_q, acc_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               s_q, s_d;
    logic [DataW-1:0]   result_q, result_d;
    logic [1:0]         nz_q, nz_d;

    logic [DataW-1:0]   sum;
    logic [DataW-1:0]   mplier_shr;

    assign sum        = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign mplier_shr = mplier_q >> 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            s_q      <= 1'b0;
            result_q <= '0;
            nz_q     <= 2'b01;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            s_q      <= s_d;
            result_q <= result_d;
            nz_q     <= nz_d;
        end
    end

    // Flush in BUSY wins over completion so an aborted op never publishes.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        s_d      = s_q;
        result_d = result_q;
        nz_d     = nz_q;
        unique case (state_q)
            IDLE: begin
                if (StartE && !FlushE) begin
                    mcand_d  = SrcA;
                    mplier_d = SrcB;
                    acc_d    = AccE ? SrcC : '0;
                    s_d      = SetFlagsE;
                    cnt_d    = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (FlushE) begin
                    state_d = IDLE;
                end else begin
                    acc_d    = sum;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_shr;
                    cnt_d    = cnt_q + CntW'(1);
                    if ((mplier_shr == '0) || (cnt_q == CntLast)) begin
                        state_d  = DONE;
                        result_d = sum;
                        nz_d     = {sum[DataW-1], (sum == '0)};
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign Busy     = (state_q == BUSY);
    assign Done     = (state_q == DONE);
    assign FlagW    = ((state_q == DONE) && s_q) ? 2'b10 : 2'b00;
    assign Result   = result_q;
    assign FlagsNZ  = nz_q;
    // Stall is raised in the issue cycle itself so Execute holds the MUL.
    assign StallMul = rst_n && (((state_q == IDLE) && StartE && !FlushE) || (state_q == BUSY));

endmodule

// File: tb/tb_mul_sequencer.sv
// Scoreboard bench for mul_sequencer: stimulus pushes expectations, a monitor checks them.
module tb_mul_sequencer;

    logic        clk;
    logic        rst_n;
    logic        StartE, AccE, SetFlagsE, FlushE;
    logic [31:0] SrcA, SrcB, SrcC;
    logic        StallMul, Busy, Done;
    logic [31:0] Result;
    logic [1:0]  FlagsNZ, FlagW;

    typedef struct packed {
        logic [31:0] res;
        logic [1:0]  nz;
        logic [1:0]  fw;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;

    exp_t sb_q[$];
    chk_t chk_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    mul_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .StartE   (StartE),
        .AccE     (AccE),
        .SetFlagsE(SetFlagsE),
        .FlushE   (FlushE),
        .SrcA     (SrcA),
        .SrcB     (SrcB),
        .SrcC     (SrcC),
        .StallMul (StallMul),
        .Busy     (Busy),
        .Done     (Done),
        .Result   (Result),
        .FlagsNZ  (FlagsNZ),
        .FlagW    (FlagW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: sole owner of the counters; drains cycle checks and Done results.
    always @(negedge clk) begin
        chk_t c;
        exp_t e;
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            n_checks++;
            if (c.act !== c.exp) begin
                n_errors++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", c.name, c.act, c.exp);
            end
        end
        if (Done === 1'b1) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_done: Result=0x%08h with no pending operation", Result);
            end else begin
                e = sb_q.pop_front();
                if ({Result, FlagsNZ, FlagW} !== {e.res, e.nz, e.fw}) begin
                    n_errors++;
                    $display("FAIL done_result: got Result=0x%08h NZ=%b W=%b expected Result=0x%08h NZ=%b W=%b",
                             Result, FlagsNZ, FlagW, e.res, e.nz, e.fw);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.act  = act;
        c.exp  = exp;
        chk_q.push_back(c);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                          input logic acc, input logic s, input int k,
                          input logic [31:0] res, input logic [1:0] nz, input logic [1:0] fw,
                          input string nm);
        int nb;
        int stalls;
        exp_t e;
        e = {res, nz, fw};
        sb_q.push_back(e);
        SrcA = a; SrcB = b; SrcC = c; AccE = acc; SetFlagsE = s; StartE = 1'b1;
        #1;
        chk({nm, "_req_stall"}, 32'(StallMul), 32'd1);
        tick();
        StartE = 1'b0;
        stalls = 1;
        nb = 0;
        while (Busy && nb < 40) begin
            nb++;
            if (StallMul) stalls++;
            tick();
        end
        chk({nm, "_busy_cycles"}, 32'(nb), 32'(k));
        chk({nm, "_stall_cycles"}, 32'(stalls), 32'(k + 1));
        chk({nm, "_done_now"}, 32'(Done), 32'd1);
        chk({nm, "_done_stall"}, 32'(StallMul), 32'd0);
        tick();
        chk({nm, "_done_pulse"}, 32'(Done), 32'd0);
    endtask

    initial begin
        exp_t e;
        rst_n = 1'b0;
        StartE = 1'b1; AccE = 1'b0; SetFlagsE = 1'b0; FlushE = 1'b0;
        SrcA = '0; SrcB = '0; SrcC = '0;
        tick();
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_flagw", 32'(FlagW), 32'd0);
        chk("rst_result", Result, 32'd0);
        chk("rst_nz", 32'(FlagsNZ), 32'd1);
        chk("rst_stall", 32'(StallMul), 32'd0);
        rst_n = 1'b1;
        StartE = 1'b0;

        run_op(32'd7, 32'd3, 32'd0, 1'b0, 1'b0, 2, 32'd21, 2'b00, 2'b00, "mul7x3");
        run_op(32'd5, 32'd0, 32'd9, 1'b1, 1'b1, 1, 32'd9, 2'b00, 2'b10, "mla_b0");
        run_op(32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 32, 32'h8000_0000, 2'b10, 2'b10, "mul_max");
        run_op(32'd0, 32'hFF, 32'd0, 1'b0, 1'b1, 8, 32'd0, 2'b01, 2'b10, "mul_zero");
        run_op(32'h0001_0000, 32'h0001_0001, 32'd3, 1'b1, 1'b0, 17, 32'h0001_0003, 2'b00, 2'b00, "mla_wrap");

        // Flush on the third BUSY cycle
        SrcA = 32'd3; SrcB = 32'hF; AccE = 1'b0; SetFlagsE = 1'b1; StartE = 1'b1;
        tick();
        StartE = 1'b0;
        tick();
        tick();
        FlushE = 1'b1;
        #1;
        chk("flush_stall_busy", 32'(StallMul), 32'd1);
        tick();
        chk("flush_busy", 32'(Busy), 32'd0);
        chk("flush_stall_drop", 32'(StallMul), 32'd0);
        chk("flush_result", Result, 32'h0001_0003);
        FlushE = 1'b0;
        tick();
        chk("flush_no_done", 32'(Done), 32'd0);

        // Start together with flush in IDLE is ignored
        StartE = 1'b1; FlushE = 1'b1;
        #1;
        chk("idle_flush_stall", 32'(StallMul), 32'd0);
        tick();
        chk("idle_flush_busy", 32'(Busy), 32'd0);
        StartE = 1'b0; FlushE = 1'b0;

        // Start held through DONE (with flush) is taken only from IDLE
        e = {32'd6, 2'b00, 2'b10};
        sb_q.push_back(e);
        SrcA = 32'd6; SrcB = 32'd1; AccE = 1'b0; SetFlagsE = 1'b1; StartE = 1'b1;
        tick();
        chk("hold_busy", 32'(Busy), 32'd1);
        SrcA = 32'd4; SetFlagsE = 1'b0;
        tick();
        FlushE = 1'b1;
        #1;
        chk("hold_done", 32'(Done), 32'd1);
        chk("hold_done_fw", 32'(FlagW), 32'd2);
        chk("hold_done_stall", 32'(StallMul), 32'd0);
        tick();
        chk("hold_idle", 32'(Busy), 32'd0);
        FlushE = 1'b0;
        e = {32'd4, 2'b00, 2'b00};
        sb_q.push_back(e);
        tick();
        StartE = 1'b0;
        chk("hold_restart", 32'(Busy), 32'd1);
        tick();
        tick();

        // Reset in the middle of BUSY
        SrcA = 32'd2; SrcB = 32'hFF; AccE = 1'b0; SetFlagsE = 1'b1; StartE = 1'b1;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(Busy), 32'd0);
        chk("mid_rst_result", Result, 32'd0);
        chk("mid_rst_nz", 32'(FlagsNZ), 32'd1);
        chk("mid_rst_flagw", 32'(FlagW), 32'd0);
        chk("mid_rst_stall", 32'(StallMul), 32'd0);
        tick();
        rst_n = 1'b1;
        StartE = 1'b0;
        run_op(32'd2, 32'd2, 32'd0, 1'b0, 1'b0, 2, 32'd4, 2'b00, 2'b00, "restart");

        tick();
        tick();
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded 100000 time units");
        $fatal(1, "timeout");
    end

endmodule
